// File: rtl/de_pipe_reg_pkg.sv
// Shared CPU definitions for the D->E pipeline register: RegDst encodings,
// control-bundle field widths and the destination-register selector.
package de_pipe_reg_pkg;

    localparam int unsigned W_REGDST   = 2;
    localparam int unsigned W_ALUSRC   = 2;
    localparam int unsigned W_ALUCTRL  = 3;
    localparam int unsigned W_MEMTOREG = 2;
    localparam int unsigned W_DMOP     = 2;
    localparam int unsigned W_TNEW     = 2;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [W_REGDST-1:0] {
        REGDST_RT   = 2'b00,
        REGDST_RD   = 2'b01,
        REGDST_RA   = 2'b10,
        REGDST_ZERO = 2'b11
    } regdst_e;

    typedef struct packed {
        logic [W_REGDST-1:0]   regdst;
        logic                  regwrite;
        logic [W_ALUSRC-1:0]   alusrc;
        logic [W_ALUCTRL-1:0]  aluctrl;
        logic                  memwrite;
        logic [W_MEMTOREG-1:0] memtoreg;
        logic [W_DMOP-1:0]     dmop;
        logic [W_TNEW-1:0]     tnew;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] ext;
        ctrl_t       ctrl;
        logic [4:0]  a3;
    } e_regs_t;

    // A non-writing instruction reports register 0 so forwarding never matches it.
    function automatic logic [4:0] dest_reg(input logic [W_REGDST-1:0] regdst,
                                            input logic                regwrite,
                                            input logic [4:0]          rt,
                                            input logic [4:0]          rd);
        logic [4:0] a3;
        a3 = 5'd0;
        case (regdst)
            REGDST_RT:   a3 = rt;
            REGDST_RD:   a3 = rd;
            REGDST_RA:   a3 = REG_RA;
            REGDST_ZERO: a3 = 5'd0;
            default:     a3 = 5'd0;
        endcase
        return regwrite ? a3 : 5'd0;
    endfunction

endpackage

// File: rtl/de_pipe_reg_if.sv
// D-stage inputs, hazard controls and registered E-stage outputs of the D->E register.
interface de_pipe_reg_if;
    import de_pipe_reg_pkg::*;

    logic                  stall;
    logic                  flush;
    logic                  en;

    logic [31:0]           D_instr, D_pc, D_rs_data, D_rt_data, D_ext;
    logic [W_REGDST-1:0]   D_regdst;
    logic                  D_regwrite;
    logic [W_ALUSRC-1:0]   D_alusrc;
    logic [W_ALUCTRL-1:0]  D_aluctrl;
    logic                  D_memwrite;
    logic [W_MEMTOREG-1:0] D_memtoreg;
    logic [W_DMOP-1:0]     D_dmop;
    logic [W_TNEW-1:0]     D_tnew;

    logic [31:0]           E_instr, E_pc, E_rs_data, E_rt_data, E_ext;
    logic [W_REGDST-1:0]   E_regdst;
    logic                  E_regwrite;
    logic [W_ALUSRC-1:0]   E_alusrc;
    logic [W_ALUCTRL-1:0]  E_aluctrl;
    logic                  E_memwrite;
    logic [W_MEMTOREG-1:0] E_memtoreg;
    logic [W_DMOP-1:0]     E_dmop;
    logic [W_TNEW-1:0]     E_tnew;
    logic [4:0]            E_a3;
    logic [W_TNEW-1:0]     M_tnew_nxt;
    logic [15:0]           bubble_cnt;

    modport master (
        output stall, flush, en,
        output D_instr, D_pc, D_rs_data, D_rt_data, D_ext,
        output D_regdst, D_regwrite, D_alusrc, D_aluctrl,
        output D_memwrite, D_memtoreg, D_dmop, D_tnew,
        input  E_instr, E_pc, E_rs_data, E_rt_data, E_ext,
        input  E_regdst, E_regwrite, E_alusrc, E_aluctrl,
        input  E_memwrite, E_memtoreg, E_dmop, E_tnew,
        input  E_a3, M_tnew_nxt, bubble_cnt
    );

    modport slave (
        input  stall, flush, en,
        input  D_instr, D_pc, D_rs_data, D_rt_data, D_ext,
        input  D_regdst, D_regwrite, D_alusrc, D_aluctrl,
        input  D_memwrite, D_memtoreg, D_dmop, D_tnew,
        output E_instr, E_pc, E_rs_data, E_rt_data, E_ext,
        output E_regdst, E_regwrite, E_alusrc, E_aluctrl,
        output E_memwrite, E_memtoreg, E_dmop, E_tnew,
        output E_a3, M_tnew_nxt, bubble_cnt
    );

endinterface

// File: rtl/de_pipe_reg_sat_cnt16.sv
// 16-bit up-counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        inc_i,
    output logic [15:0] cnt_o
);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: defaulting the next state to the current one first means no path can leave it unassigned, so no latch is inferred.
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/de_pipe_reg.sv
// D->E pipeline register: hold > bubble > load, with destination-register
// decode, next-stage Tnew and a saturating bubble counter.
module de_pipe_reg
    import de_pipe_reg_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    de_pipe_reg_if.slave bus
);

    e_regs_t     e_q, e_d;
    ctrl_t       d_ctrl;
    logic        bubble;
    logic [15:0] bubble_cnt;

    assign d_ctrl = '{regdst:   bus.D_regdst,   regwrite: bus.D_regwrite,
                      alusrc:   bus.D_alusrc,   aluctrl:  bus.D_aluctrl,
                      memwrite: bus.D_memwrite, memtoreg: bus.D_memtoreg,
                      dmop:     bus.D_dmop,     tnew:     bus.D_tnew};

    // Hold wins over bubble, so a frozen stage never counts a bubble.
    assign bubble = bus.en & (bus.stall | bus.flush);

    always_comb begin
        e_d = e_q;
        if (bubble) begin
            e_d = '0;
        end else if (bus.en) begin
            e_d.instr   = bus.D_instr;
            e_d.pc      = bus.D_pc;
            e_d.rs_data = bus.D_rs_data;
            e_d.rt_data = bus.D_rt_data;
            e_d.ext     = bus.D_ext;
            e_d.ctrl    = d_ctrl;
            e_d.a3      = dest_reg(bus.D_regdst, bus.D_regwrite,
                                   bus.D_instr[20:16], bus.D_instr[15:11]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) e_q <= '0;
        else          e_q <= e_d;
    end

    sat_cnt16 u_bubble_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc_i   (bubble),
        .cnt_o   (bubble_cnt)
    );

    assign bus.E_instr    = e_q.instr;
    assign bus.E_pc       = e_q.pc;
    assign bus.E_rs_data  = e_q.rs_data;
    assign bus.E_rt_data  = e_q.rt_data;
    assign bus.E_ext      = e_q.ext;
    assign bus.E_regdst   = e_q.ctrl.regdst;
    assign bus.E_regwrite = e_q.ctrl.regwrite;
    assign bus.E_alusrc   = e_q.ctrl.alusrc;
    assign bus.E_aluctrl  = e_q.ctrl.aluctrl;
    assign bus.E_memwrite = e_q.ctrl.memwrite;
    assign bus.E_memtoreg = e_q.ctrl.memtoreg;
    assign bus.E_dmop     = e_q.ctrl.dmop;
    assign bus.E_tnew     = e_q.ctrl.tnew;
    assign bus.E_a3       = e_q.a3;
    assign bus.bubble_cnt = bubble_cnt;

    assign bus.M_tnew_nxt = (e_q.ctrl.tnew == '0) ? '0 : e_q.ctrl.tnew - 2'd1;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed bench for de_pipe_reg: load, a3 decode, bubbles, hold, saturation, resets.
module tb_de_pipe_reg;

    logic clk = 1'b0;
    logic reset_n;
    int   total = 0;
    int   bad   = 0;

    de_pipe_reg_if bus ();

    de_pipe_reg dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [1:0] regdst, input logic regwrite,
                         input logic memwrite, input logic [1:0] tnew);
        bus.D_instr    = instr;
        bus.D_pc       = pc;
        bus.D_rs_data  = 32'h1111_0001;
        bus.D_rt_data  = 32'h2222_0002;
        bus.D_ext      = 32'h0000_4020;
        bus.D_regdst   = regdst;
        bus.D_regwrite = regwrite;
        bus.D_alusrc   = 2'b01;
        bus.D_aluctrl  = 3'b110;
        bus.D_memwrite = memwrite;
        bus.D_memtoreg = 2'b10;
        bus.D_dmop     = 2'b11;
        bus.D_tnew     = tnew;
    endtask

    initial begin
        reset_n   = 1'b1;
        bus.en    = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_d(32'hFFFF_FFFF, 32'h0040_0000, 2'b01, 1'b1, 1'b1, 2'd3);
        #1 reset_n = 1'b0;
        #2;
        check("reset_async_instr", bus.E_instr, 32'h0);
        check("reset_async_cnt", {16'h0, bus.bubble_cnt}, 32'h0);

        // Clocks under reset with live inputs must not load anything.
        step();
        step();
        check("reset_hold_instr", bus.E_instr, 32'h0);
        check("reset_hold_a3", {27'h0, bus.E_a3}, 32'h0);
        check("reset_hold_tnew_nxt", {30'h0, bus.M_tnew_nxt}, 32'h0);
        check("reset_hold_memwrite", {31'h0, bus.E_memwrite}, 32'h0);
        reset_n = 1'b1;

        // Load an R-type add: destination is rd = 8, one-cycle latency.
        set_d(32'h012A_4020, 32'h0040_0004, 2'b01, 1'b1, 1'b0, 2'd1);
        #1;
        check("load_latency_instr", bus.E_instr, 32'h0);
        step();
        check("load_instr", bus.E_instr, 32'h012A_4020);
        check("load_a3_rd", {27'h0, bus.E_a3}, 32'd8);
        check("load_pc", bus.E_pc, 32'h0040_0004);
        check("load_rs", bus.E_rs_data, 32'h1111_0001);
        check("load_rt", bus.E_rt_data, 32'h2222_0002);
        check("load_ext", bus.E_ext, 32'h0000_4020);
        check("load_aluctrl", {29'h0, bus.E_aluctrl}, 32'd6);
        check("load_alusrc", {30'h0, bus.E_alusrc}, 32'd1);
        check("load_memtoreg", {30'h0, bus.E_memtoreg}, 32'd2);
        check("load_dmop", {30'h0, bus.E_dmop}, 32'd3);
        check("load_regdst", {30'h0, bus.E_regdst}, 32'd1);
        check("load_regwrite", {31'h0, bus.E_regwrite}, 32'd1);
        check("tnew1_nxt", {30'h0, bus.M_tnew_nxt}, 32'd0);

        // regdst = RT selects instr[20:16] = 10.
        set_d(32'h012A_4020, 32'h0040_0008, 2'b00, 1'b1, 1'b0, 2'd0);
        step();
        check("a3_rt", {27'h0, bus.E_a3}, 32'd10);
        check("tnew0_nxt", {30'h0, bus.M_tnew_nxt}, 32'd0);

        // Non-writing instruction reports a3 = 0.
        set_d(32'h012A_4020, 32'h0040_000C, 2'b01, 1'b0, 1'b0, 2'd0);
        step();
        check("a3_nowrite", {27'h0, bus.E_a3}, 32'd0);

        // regdst = ZERO.
        set_d(32'h012A_4020, 32'h0040_0010, 2'b11, 1'b1, 1'b0, 2'd0);
        step();
        check("a3_zero", {27'h0, bus.E_a3}, 32'd0);

        // jal: a3 = 31, Tnew 2 -> 1, then Tnew 3 -> 2.
        set_d(32'h0C10_0000, 32'h0040_0014, 2'b10, 1'b1, 1'b0, 2'd2);
        step();
        check("jal_a3", {27'h0, bus.E_a3}, 32'd31);
        check("jal_tnew_nxt", {30'h0, bus.M_tnew_nxt}, 32'd1);
        set_d(32'h0C10_0000, 32'h0040_0018, 2'b10, 1'b1, 1'b0, 2'd3);
        step();
        check("tnew3_nxt", {30'h0, bus.M_tnew_nxt}, 32'd2);

        // Store-like word (memwrite = 1, a3 = rt = 8) so a bubble visibly clears it.
        set_d(32'hAD28_0004, 32'h0040_001C, 2'b00, 1'b1, 1'b1, 2'd3);
        step();
        check("st_memwrite", {31'h0, bus.E_memwrite}, 32'd1);
        check("st_a3", {27'h0, bus.E_a3}, 32'd8);
        check("cnt_before_stall", {16'h0, bus.bubble_cnt}, 32'd0);

        bus.stall = 1'b1;
        step();
        check("stall1_regwrite", {31'h0, bus.E_regwrite}, 32'd0);
        check("stall1_memwrite", {31'h0, bus.E_memwrite}, 32'd0);
        check("stall1_a3", {27'h0, bus.E_a3}, 32'd0);
        check("stall1_instr", bus.E_instr, 32'h0);
        check("stall1_cnt", {16'h0, bus.bubble_cnt}, 32'd1);
        step();
        check("stall2_regwrite", {31'h0, bus.E_regwrite}, 32'd0);
        check("stall2_memwrite", {31'h0, bus.E_memwrite}, 32'd0);
        check("stall2_a3", {27'h0, bus.E_a3}, 32'd0);
        check("stall2_cnt", {16'h0, bus.bubble_cnt}, 32'd2);

        // Reload, then freeze with stall asserted: nothing moves.
        bus.stall = 1'b0;
        step();
        check("reload_memwrite", {31'h0, bus.E_memwrite}, 32'd1);
        bus.en    = 1'b0;
        bus.stall = 1'b1;
        set_d(32'h1234_5678, 32'h0040_0020, 2'b01, 1'b1, 1'b0, 2'd1);
        step();
        step();
        check("hold_instr", bus.E_instr, 32'hAD28_0004);
        check("hold_pc", bus.E_pc, 32'h0040_001C);
        check("hold_memwrite", {31'h0, bus.E_memwrite}, 32'd1);
        check("hold_a3", {27'h0, bus.E_a3}, 32'd8);
        check("hold_cnt", {16'h0, bus.bubble_cnt}, 32'd2);

        // Flush alone, then stall and flush together: one bubble each.
        bus.en    = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        step();
        check("flush_instr", bus.E_instr, 32'h0);
        check("flush_cnt", {16'h0, bus.bubble_cnt}, 32'd3);
        bus.stall = 1'b1;
        step();
        check("stall_flush_cnt", {16'h0, bus.bubble_cnt}, 32'd4);
        bus.flush = 1'b0;

        // Drive the counter up to FFFE, then three more bubbles must stop at FFFF.
        repeat (32'hFFFE - 32'd4) @(posedge clk);
        #1;
        check("preload_cnt", {16'h0, bus.bubble_cnt}, 32'h0000_FFFE);
        step();
        check("sat_cnt_1", {16'h0, bus.bubble_cnt}, 32'h0000_FFFF);
        step();
        step();
        check("sat_cnt_3", {16'h0, bus.bubble_cnt}, 32'h0000_FFFF);

        // Mid-operation reset between edges clears outputs before the next edge.
        bus.stall = 1'b0;
        set_d(32'h0C10_0000, 32'h0040_0024, 2'b10, 1'b1, 1'b1, 2'd3);
        step();
        check("pre_reset_a3", {27'h0, bus.E_a3}, 32'd31);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_instr", bus.E_instr, 32'h0);
        check("midrst_pc", bus.E_pc, 32'h0);
        check("midrst_a3", {27'h0, bus.E_a3}, 32'd0);
        check("midrst_memwrite", {31'h0, bus.E_memwrite}, 32'd0);
        check("midrst_tnew_nxt", {30'h0, bus.M_tnew_nxt}, 32'd0);
        check("midrst_cnt", {16'h0, bus.bubble_cnt}, 32'd0);

        // First load after release.
        #3 reset_n = 1'b1;
        step();
        check("post_reset_load_a3", {27'h0, bus.E_a3}, 32'd31);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/de_pipe_reg.md
DE_PIPE_REG -- requirements
Module: de_pipe_reg

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports stall  in  1  (hazard unit: insert bubble) and flush  in  1  (insert bubble, same effect as stall).
REQ-004 SHALL have port en  in  1  (0 = freeze E register, hold contents).
REQ-005 SHALL have ports D_instr  in  32  and D_pc  in  32.
REQ-006 SHALL have ports D_rs_data, D_rt_data and D_ext  in  32 each.
REQ-007 SHALL have D-stage control inputs: D_regdst in 2, D_regwrite in 1, D_alusrc in 2, D_aluctrl in 3, D_memwrite in 1, D_memtoreg in 2, D_dmop in 2, D_tnew in 2.
REQ-008 SHALL have registered E_ outputs, one per D_ input of REQ-005..007, with the same widths.
REQ-009 SHALL have output E_a3  out  5  (registered destination register).
REQ-010 SHALL have output M_tnew_nxt  out  2  (combinational, Tnew handed to the M stage).
REQ-011 SHALL have output bubble_cnt  out  16  (number of bubbles inserted).

Function
REQ-012 SHALL apply, on each clk edge, the first matching action in this priority: hold (en=0) > bubble (stall|flush) > load.
REQ-013 SHALL, on hold, keep every register including bubble_cnt unchanged; stall/flush are ignored that cycle.
REQ-014 SHALL, on bubble, clear every E_ output and E_a3 to 0, producing a nop with regwrite=0 and memwrite=0.
REQ-015 SHALL, on load, copy every D_ input to its E_ output (latency 1 cycle).
REQ-016 SHALL compute E_a3 at load from D_regdst: 00 = D_instr[20:16], 01 = D_instr[15:11], 10 = 5'd31, 11 = 5'd0.
REQ-017 SHALL force E_a3 to 0 at load when D_regwrite=0, so that forwarding logic never matches a non-writing instruction.
REQ-018 SHALL drive M_tnew_nxt = E_tnew-1 saturating at 0 (E_tnew 0 -> 0, 1 -> 0, 2 -> 1, 3 -> 2).
REQ-019 SHALL increment bubble_cnt by 1 for each bubble actually inserted, saturating at 16'hFFFF with no wrap.
REQ-020 SHALL treat simultaneous stall and flush as a single bubble (bubble_cnt increments by 1).

Reset
REQ-021 SHALL, when reset_n=0, immediately (without waiting for clk) drive every E_ output, E_a3 and bubble_cnt to 0.
REQ-022 SHALL make M_tnew_nxt equal 0 throughout reset.
REQ-023 SHALL override en, stall and flush while reset_n=0; the first load occurs on the first clk edge after reset_n rises.

Structure
REQ-024 SHALL take from the shared CPU package: the RegDst encodings (RT, RD, RA, ZERO), the constant 5'd31, and the control-bundle field widths.
REQ-025 SHALL be one flat module, except that the saturating counter of REQ-019 MAY be the sub-module sat_cnt16.
REQ-026 SHALL contain no combinational path from D_ inputs to outputs; M_tnew_nxt depends only on E_tnew.

Verification
REQ-027 SHALL cover load: en=1, stall=0, D_instr=32'h012A4020, D_regdst=01, D_regwrite=1 -> next cycle E_instr=32'h012A4020, E_a3=8.
REQ-028 SHALL cover jal: D_regdst=10, D_regwrite=1, D_tnew=2 -> E_a3=31, M_tnew_nxt=1.
REQ-029 SHALL cover stall: stall=1 for 2 cycles -> E_regwrite=0, E_memwrite=0 and E_a3=0 both cycles; bubble_cnt goes 0 -> 2.
REQ-030 SHALL cover hold over stall: en=0 with stall=1 -> E_ outputs unchanged and bubble_cnt unchanged.
REQ-031 SHALL cover saturation: preload bubble_cnt to 16'hFFFE, apply 3 bubbles -> bubble_cnt=16'hFFFF.
REQ-032 SHALL cover mid-operation reset: assert reset_n=0 between clk edges -> all outputs read 0 before the next clk edge.
